// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram-like memory port between the IF (inst) and MEM (data) requesters.
//   clk, rst                 : clock, asynchronous active-high reset
//   inst_sram_en/addr        : fetch request (level, held until inst_done) and virtual address
//   inst_rdata/done/stallreq : fetched word, one-cycle completion pulse, stall request
//   data_sram_en/wen/addr/wdata : load/store request, byte strobes (0 = read), virtual address, store data
//   data_rdata/done/stallreq : load word, one-cycle completion pulse, stall request
//   mem_req/wr/wstrb/addr/wdata : single memory port request, driven from registers latched at grant
//   mem_addr_ok/data_ok/rdata   : memory address accept, data/write completion, read data
module sram_port_arbiter #(
    parameter int DATA_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    output logic        inst_stallreq,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        data_stallreq,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_MAX);
    state_t           state;
    logic             owner_data;
    logic [CNT_W-1:0] cnt;
    logic             grant_data;
    logic [31:0]      grant_addr;
    logic             finish;
    // kseg0/kseg1 map onto the low 512 MiB of physical space
    function automatic logic [31:0] translate(input logic [31:0] a);
        return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
    endfunction
    // data wins unless it has already taken DATA_MAX grants in a row over a waiting fetch
    always_comb begin
        grant_data = data_sram_en & ~(inst_sram_en & (cnt == CNT_MAX));
        grant_addr = translate(grant_data ? data_sram_addr : inst_sram_addr);
        finish     = mem_data_ok & ((state == ADDR & mem_addr_ok) | (state == WAIT));
    end
    assign inst_stallreq = inst_sram_en & ~inst_done;
    assign data_stallreq = data_sram_en & ~data_done;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            if (!inst_sram_en) cnt <= '0;
            else if (state == IDLE) cnt <= grant_data ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1) : '0;
            case (state)
                IDLE: if (inst_sram_en || data_sram_en) begin
                    owner_data <= grant_data;
                    mem_addr   <= grant_addr;
                    mem_wr     <= grant_data & (|data_sram_wen);
                    mem_wstrb  <= grant_data ? data_sram_wen : 4'h0;
                    mem_wdata  <= grant_data ? data_sram_wdata : 32'h0;
                    mem_req    <= 1'b1;
                    state      <= ADDR;
                end
                ADDR: if (mem_addr_ok) begin
                    mem_req <= 1'b0;
                    state   <= mem_data_ok ? DONE : WAIT;
                end
                WAIT: if (mem_data_ok) state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (finish && owner_data) data_rdata <= mem_rdata;
            if (finish && !owner_data) inst_rdata <= mem_rdata;
            inst_done <= finish & ~owner_data;
            data_done <= finish & owner_data;
        end
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one external sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Arbitrates between the two requesters and sequences the address/data handshake.
- Performs kseg0/kseg1 address translation.
- Produces per-requester stall requests for the pipeline stall controller.
- Sits between the pipeline's inst/data SRAM-style outputs and the single bus/memory interface.

Parameters:
- DATA_MAX, 4: maximum consecutive data grants while an instruction request is waiting; the next grant is then forced to instruction.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > DATA_MAX.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- inst_sram_en  input  1  instruction request (level; held until inst_done)
- inst_sram_addr  input  32  fetch virtual address
- inst_rdata  output  32  fetched instruction, valid while inst_done=1
- inst_done  output  1  one-cycle completion pulse for the instruction request
- inst_stallreq  output  1  inst_sram_en & ~inst_done
- data_sram_en  input  1  data request (level; held until data_done)
- data_sram_wen  input  4  byte write strobes; 0 means read
- data_sram_addr  input  32  data virtual address
- data_sram_wdata  input  32  store data
- data_rdata  output  32  load data, valid while data_done=1
- data_done  output  1  one-cycle completion pulse for the data request
- data_stallreq  output  1  data_sram_en & ~data_done
- mem_req  output  1  memory request
- mem_wr  output  1  1 = write
- mem_wstrb  output  4  byte strobes
- mem_addr  output  32  physical address
- mem_wdata  output  32  write data
- mem_addr_ok  input  1  memory accepted the address this cycle
- mem_data_ok  input  1  read data returned / write completed this cycle
- mem_rdata  input  32  read data, valid with mem_data_ok

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the starvation counter clears.
  - mem_req, mem_wr, inst_done and data_done are 0.
  - mem_wstrb, mem_addr, mem_wdata, inst_rdata and data_rdata are 0.
  - A transaction in flight is abandoned. The memory side is reset by the same rst, so no data_ok may follow reset.
- Address translation: if addr[31:30]==2'b10 (kseg0/kseg1), mem_addr = {3'b000, addr[28:0]}; otherwise addr passes through unchanged.
- IDLE:
  - Arbitrates when either enable is high, using the priority rules below.
  - Latches owner, translated address, wr=(wen!=0), wstrb=wen and wdata into registers, then moves to ADDR.
  - mem_req is 0 in IDLE.
  - For an instruction grant, wr=0 and wstrb=0.
- Priority:
  - Data wins by default.
  - Instruction wins when data_sram_en=0, or when the counter equals DATA_MAX with inst_sram_en=1.
- Counter:
  - Increments on each data grant made while inst_sram_en=1.
  - Clears on any instruction grant, and in any cycle where inst_sram_en=0.
  - Saturates at DATA_MAX.
- ADDR:
  - mem_req=1, driven from the latched registers (stable; not recomputed from requester inputs).
  - On mem_addr_ok, goes to WAIT.
  - If mem_data_ok is also high in the same cycle, goes directly to DONE and captures mem_rdata.
- WAIT: mem_req=0. On mem_data_ok, captures mem_rdata into the owner's rdata register and goes to DONE.
- DONE (one cycle):
  - The owner's done=1 with rdata valid. The other requester's done stays 0.
  - Returns to IDLE next cycle. No new grant is made in DONE.
- Latency:
  - Request seen at cycle t, mem_req from t+1, addr_ok at t+a, data_ok at t+d (d>=a), done at t+d+1.
  - Minimum (addr_ok and data_ok both at t+1): done at t+2.
- Writes complete exactly like reads; rdata is don't-care for writes.
- A requester dropping its enable mid-transaction does not abort it: the transaction completes and done pulses (ignored). The stall request follows the enable immediately.
- An enable still high in the cycle after done is treated as a new request (re-access). This avoidance is the requester's responsibility.
- mem_data_ok in IDLE, ADDR-without-addr_ok or DONE is ignored.
- Only one outstanding transaction at a time.

Test Plan:
- Reset fetch: rst released, inst_sram_en=1, addr=0xbfbffffc, memory gives addr_ok+data_ok one cycle after mem_req with rdata=0x3c1dbfc0.
  - Required: mem_addr=0x1fbffffc, mem_wr=0; inst_done and inst_rdata=0x3c1dbfc0 two cycles after the request; inst_stallreq high until then.
- Simultaneous requests: inst 0x80000100 and data load 0xa0001000 in the same cycle.
  - Required: data granted first (mem_addr=0x00001000); the instruction request is issued only after data_done, with mem_addr=0x00000100.
- Store:
  - Stimulus: data_sram_wen=4'b0011, wdata=0x0000beef, addr=0x80002004, addr_ok after 2 cycles, data_ok 3 cycles later.
  - Required: mem_wr=1, mem_wstrb=0011, mem_addr=0x00002004; mem_req held through the addr_ok wait and dropped after addr_ok; data_done exactly one cycle after data_ok.
- Starvation: inst_sram_en held high while data requests back-to-back continuously.
  - Required: with DATA_MAX=4, exactly 4 data transactions, then one instruction transaction, then data again.
- Reset mid-transaction: assert rst while in WAIT.
  - Required: mem_req and both done outputs go 0 immediately (asynchronously). After release, a fresh instruction request proceeds normally.
- Unmapped address: data read at 0x1fc00000 (addr[31:30]!=2'b10).
  - Required: mem_addr=0x1fc00000 unchanged; data_rdata equals the returned value.
